// File: rtl/key_pkg.sv
// Shared types and default timing constants for the front-panel key controller.
// The debounce state enum is visible to both the debouncer and any checker that binds to it.
package key_pkg;

    typedef enum logic [1:0] {
        DEB_IDLE,
        DEB_PWAIT,
        DEB_HELD,
        DEB_RWAIT
    } deb_state_t;

    localparam int DEB_CYC_DEF  = 500_000;
    localparam int LONG_CYC_DEF = 50_000_000;
    localparam int REP_CYC_DEF  = 10_000_000;
    localparam int PAGES_DEF    = 4;

endpackage

// File: rtl/key_deb.sv
// One key: 2-flop synchroniser, debounce FSM, hold timer and auto-repeat timer.
// The release event is named rel because release is a reserved word.
module key_deb
    import key_pkg::*;
#(
    parameter int DEB_CYC  = DEB_CYC_DEF,
    parameter int LONG_CYC = LONG_CYC_DEF,
    parameter int REP_CYC  = REP_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    output logic       pressed,
    output logic       press,
    output logic       rel,
    output logic       long,
    output logic       rep,
    output deb_state_t state
);

    localparam int DW = $clog2(DEB_CYC);
    localparam int HW = $clog2(LONG_CYC);
    localparam int RW = $clog2(REP_CYC + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REP_CYC - 1);

    logic          sync1;
    logic          sync2;
    deb_state_t    nxt;
    logic [DW-1:0] deb_cnt;
    logic [DW-1:0] deb_nxt;
    logic [HW-1:0] hold_cnt;
    logic [RW-1:0] rep_cnt;
    logic          long_done;
    logic          active;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            state   <= DEB_IDLE;
            deb_cnt <= '0;
            pressed <= 1'b0;
        end else begin
            sync1   <= key;
            sync2   <= sync1;
            state   <= nxt;
            deb_cnt <= deb_nxt;
            pressed <= (nxt == DEB_HELD) || (nxt == DEB_RWAIT);
        end
    end

    // A wait state accepts the new level on its DEB_CYC-th consecutive sample.
    always_comb begin
        nxt     = state;
        deb_nxt = deb_cnt;
        press   = 1'b0;
        rel     = 1'b0;
        unique case (state)
            DEB_IDLE: begin
                if (!sync2) begin
                    nxt     = DEB_PWAIT;
                    deb_nxt = '0;
                end
            end
            DEB_PWAIT: begin
                if (sync2) begin
                    nxt     = DEB_IDLE;
                    deb_nxt = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    nxt     = DEB_HELD;
                    deb_nxt = '0;
                    press   = 1'b1;
                end else begin
                    deb_nxt = deb_cnt + DW'(1);
                end
            end
            DEB_HELD: begin
                if (sync2) begin
                    nxt     = DEB_RWAIT;
                    deb_nxt = '0;
                end
            end
            DEB_RWAIT: begin
                if (!sync2) begin
                    nxt     = DEB_HELD;
                    deb_nxt = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    nxt     = DEB_IDLE;
                    deb_nxt = '0;
                    rel     = 1'b1;
                end else begin
                    deb_nxt = deb_cnt + DW'(1);
                end
            end
            default: begin
                nxt     = DEB_IDLE;
                deb_nxt = '0;
            end
        endcase
    end

    assign active = (state == DEB_HELD) || (state == DEB_RWAIT);
    // Timed events are dropped on the edge that returns the key to IDLE.
    assign long   = active && !long_done && (hold_cnt == HOLD_LAST) && !rel;
    assign rep    = active && long_done && (rep_cnt == REP_LAST) && !rel;

    always_ff @(posedge clk) begin
        if (rst || press) begin
            hold_cnt  <= '0;
            rep_cnt   <= '0;
            long_done <= 1'b0;
        end else if (active) begin
            if (long) begin
                long_done <= 1'b1;
                rep_cnt   <= '0;
            end else if (long_done) begin
                rep_cnt <= (rep_cnt == REP_LAST) ? '0 : rep_cnt + RW'(1);
            end else if (hold_cnt != HOLD_LAST) begin
                hold_cnt <= hold_cnt + HW'(1);
            end
        end
    end

endmodule

// File: rtl/key_ctl.sv
// Front-panel key controller: turns two debounced keys into page select, freeze flag,
// statistics-clear strobe and the status LEDs for the 7-segment display stage.
module key_ctl
    import key_pkg::*;
#(
    parameter int  DEB_CYC  = DEB_CYC_DEF,
    parameter int  LONG_CYC = LONG_CYC_DEF,
    parameter int  REP_CYC  = REP_CYC_DEF,
    parameter int  PAGES    = PAGES_DEF,
    localparam int PW       = $clog2(PAGES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key0,
    input  logic          key1,
    output logic [PW-1:0] page,
    output logic          freeze,
    output logic          clr,
    output logic          k0_evt,
    output logic [3:0]    led
);

    localparam logic [PW-1:0] PAGE_LAST = PW'(PAGES - 1);

    logic       k0_pressed, k0_press, k0_rel, k0_long, k0_rep;
    logic       k1_pressed, k1_press, k1_rel, k1_long, k1_rep;
    deb_state_t k0_state, k1_state;
    logic       k0_adv;
    logic       k1_long_seen;
    logic [1:0] page_lo;
    logic       unused_sigs;

    key_deb #(.DEB_CYC(DEB_CYC), .LONG_CYC(LONG_CYC), .REP_CYC(REP_CYC)) u_deb0 (
        .clk     (clk),
        .rst     (rst),
        .key     (key0),
        .pressed (k0_pressed),
        .press   (k0_press),
        .rel     (k0_rel),
        .long    (k0_long),
        .rep     (k0_rep),
        .state   (k0_state)
    );

    key_deb #(.DEB_CYC(DEB_CYC), .LONG_CYC(LONG_CYC), .REP_CYC(REP_CYC)) u_deb1 (
        .clk     (clk),
        .rst     (rst),
        .key     (key1),
        .pressed (k1_pressed),
        .press   (k1_press),
        .rel     (k1_rel),
        .long    (k1_long),
        .rep     (k1_rep),
        .state   (k1_state)
    );

    assign k0_adv = k0_press | k0_long | k0_rep;

    always_ff @(posedge clk) begin
        if (rst) begin
            page         <= '0;
            freeze       <= 1'b0;
            clr          <= 1'b0;
            k0_evt       <= 1'b0;
            k1_long_seen <= 1'b0;
        end else begin
            k0_evt <= k0_adv;
            clr    <= k1_long;
            if (k0_adv) begin
                page <= (page == PAGE_LAST) ? '0 : page + PW'(1);
            end
            // A key1 release only toggles freeze if that hold never reached long.
            if (k1_press) begin
                k1_long_seen <= 1'b0;
            end else if (k1_long) begin
                k1_long_seen <= 1'b1;
            end
            if (k1_rel && !k1_long_seen) begin
                freeze <= ~freeze;
            end
        end
    end

    assign page_lo     = 2'(page);
    assign led         = {freeze, k0_pressed, page_lo};
    assign unused_sigs = ^{k0_rel, k1_pressed, k1_rep, k0_state, k1_state};

endmodule
